// File: rtl/hex_print_pkg.sv
// Shared types and constants for the hex word printer.
// Contents:
//   hex_print_state_t : printer FSM states
//   ASCII_*           : character codes the printer emits
package hex_print_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PFX0   = 3'd1,
        PFX1   = 3'd2,
        DIGITS = 3'd3,
        CR     = 3'd4,
        LF     = 3'd5
    } hex_print_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_X    = 8'h78;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    // 'A' minus 10, so that nibble 10..15 maps onto 'A'..'F'
    localparam logic [7:0] ASCII_LETTER_BASE = 8'h37;

endpackage

// File: rtl/bin_to_hex_ascii.sv
// Nibble to uppercase ASCII hex digit converter (combinational).
// Ports:
//   nibble : in  4  binary value 0..15
//   ascii  : out 8  '0'..'9' or 'A'..'F'
module bin_to_hex_ascii
    import hex_print_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits map from '0'; letters map from 'A' - 10
    always_comb begin
        ascii = ASCII_ZERO;
        if (nibble < 4'hA) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_LETTER_BASE + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/hex_word_printer.sv
// Serialises a WIDTH-bit word into ASCII hex characters, MSB nibble first,
// one character per out_valid/out_ready handshake, optionally prefixed by "0x".
// Optional feature macro: HEX_PRINT_NEWLINE_EN (append CR, LF after the digits).
// Ports:
//   clk       : in   1      clock, posedge
//   rst_n     : in   1      synchronous active-low reset
//   in_valid  : in   1      word_in valid
//   in_ready  : out  1      word accepted this cycle (IDLE only)
//   word_in   : in   WIDTH  word to print
//   out_valid : out  1      out_data holds a character
//   out_ready : in   1      downstream accepts out_data
//   out_data  : out  8      ASCII character
//   busy      : out  1      word in progress
module hex_word_printer
    import hex_print_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHOW_PREFIX = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] word_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("hex_word_printer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    hex_print_state_t state_r, state_nxt_s;
    logic [WIDTH-1:0] word_r, word_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [3:0]       nibble_s;
    logic [7:0]       hex_s;
    logic             accept_s;

    assign nibble_s  = word_r[4*cnt_r +: 4];
    // Outputs are forced inactive while reset is asserted, not just after the edge
    assign out_valid = rst_n && (state_r != IDLE);
    assign busy      = out_valid;
    assign in_ready  = rst_n && (state_r == IDLE);
    assign accept_s  = out_valid && out_ready;

    bin_to_hex_ascii u_conv (
        .nibble (nibble_s),
        .ascii  (hex_s)
    );

    // State, word and nibble counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            word_r  <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            word_r  <= word_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: capture in IDLE, advance only on an accepted character
    always_comb begin
        state_nxt_s = state_r;
        word_nxt_s  = word_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    word_nxt_s  = word_in;
                    cnt_nxt_s   = CNT_LAST;
                    state_nxt_s = (SHOW_PREFIX != 0) ? PFX0 : DIGITS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PFX0: begin
                if (accept_s) begin
                    state_nxt_s = PFX1;
                end else begin
                    state_nxt_s = PFX0;
                end
            end
            PFX1: begin
                if (accept_s) begin
                    state_nxt_s = DIGITS;
                end else begin
                    state_nxt_s = PFX1;
                end
            end
            DIGITS: begin
                if (accept_s && cnt_r == '0) begin
`ifdef HEX_PRINT_NEWLINE_EN
                    state_nxt_s = CR;
`else
                    state_nxt_s = IDLE;
`endif
                end else if (accept_s) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end else begin
                    state_nxt_s = DIGITS;
                end
            end
`ifdef HEX_PRINT_NEWLINE_EN
            CR: begin
                if (accept_s) begin
                    state_nxt_s = LF;
                end else begin
                    state_nxt_s = CR;
                end
            end
            LF: begin
                if (accept_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LF;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output byte select by state; zero when idle or in reset
    always_comb begin
        out_data = 8'h00;
        if (!rst_n) begin
            out_data = 8'h00;
        end else begin
            case (state_r)
                PFX0:    out_data = ASCII_ZERO;
                PFX1:    out_data = ASCII_X;
                DIGITS:  out_data = hex_s;
`ifdef HEX_PRINT_NEWLINE_EN
                CR:      out_data = ASCII_CR;
                LF:      out_data = ASCII_LF;
`endif
                default: out_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_printer.sv
// Directed self-checking bench for hex_word_printer.
// dut  : WIDTH=32, SHOW_PREFIX=1
// dut8 : WIDTH=8,  SHOW_PREFIX=0
module tb_hex_word_printer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] word_in;
    logic [7:0]  out_data;

    logic        in8_valid, in8_ready, out8_valid, out8_ready, busy8;
    logic [7:0]  word8, out8_data;

    int ncmp  = 0;
    int nfail = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    hex_word_printer #(.WIDTH(32), .SHOW_PREFIX(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .word_in(word_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    hex_word_printer #(.WIDTH(8), .SHOW_PREFIX(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready),
        .word_in(word8), .out_valid(out8_valid), .out_ready(out8_ready),
        .out_data(out8_data), .busy(busy8)
    );

    // Count accepted output characters of the 32-bit printer
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) accepted <= accepted + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) r = 8'd48 + {4'd0, n};
        else           r = 8'd55 + {4'd0, n};
        return r;
    endfunction

    function automatic bq_t expect_word(input logic [31:0] w, input int nib, input bit pfx);
        bq_t q;
        logic [3:0] n;
        if (pfx) begin
            q.push_back(8'h30);
            q.push_back(8'h78);
        end
        for (int i = nib - 1; i >= 0; i--) begin
            n = w[4*i +: 4];
            q.push_back(hexc(n));
        end
`ifdef HEX_PRINT_NEWLINE_EN
        q.push_back(8'h0D);
        q.push_back(8'h0A);
`endif
        return q;
    endfunction

    // Consume 'upto' characters from the 32-bit printer; full stream also checks the idle bubble
    task automatic stream(input bq_t exp, input int upto, input bit rnd, input string tag);
        int idx = 0;
        int budget = 0;
        while (idx < upto && budget < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp[idx]});
            chk({tag, "_inrdy_busy"}, {31'd0, in_ready}, 32'd0);
            if (out_ready) idx++;
            step();
            budget++;
        end
        if (budget >= 400) chk({tag, "_timeout"}, 32'(idx), 32'(upto));
        if (upto == exp.size()) begin
            chk({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_end_inrdy"}, {31'd0, in_ready}, 32'd1);
            chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        bq_t e, e2;
        int base;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; word_in = 32'd0;
        in8_valid = 1'b0; out8_ready = 1'b1; word8 = 8'd0;
        step(); step();
        chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_inrdy", {31'd0, in_ready}, 32'd1);

        // 1: DEADBEEF at full rate, hand-written byte list
        e = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
`ifdef HEX_PRINT_NEWLINE_EN
        e.push_back(8'h0D);
        e.push_back(8'h0A);
`endif
        in_valid = 1'b1; word_in = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        stream(e, e.size(), 1'b0, "t1");

        // 2: back-pressure, stall holds data
        in_valid = 1'b1; word_in = 32'h0000_00A5;
        step();
        in_valid = 1'b0;
        stream(expect_word(32'h0000_00A5, 8, 1'b1), expect_word(32'h0000_00A5, 8, 1'b1).size(), 1'b1, "t2");

        // 3: 8-bit, no prefix
        e = '{8'h39, 8'h43};
`ifdef HEX_PRINT_NEWLINE_EN
        e.push_back(8'h0D);
        e.push_back(8'h0A);
`endif
        chk("t3_inrdy", {31'd0, in8_ready}, 32'd1);
        in8_valid = 1'b1; word8 = 8'h9C;
        step();
        in8_valid = 1'b0;
        foreach (e[i]) begin
            chk("t3_valid", {31'd0, out8_valid}, 32'd1);
            chk("t3_data", {24'd0, out8_data}, {24'd0, e[i]});
            step();
        end
        chk("t3_end_valid", {31'd0, out8_valid}, 32'd0);
        chk("t3_end_inrdy", {31'd0, in8_ready}, 32'd1);

        // 4: back-to-back with in_valid held
        in_valid = 1'b1; word_in = 32'h0;
        step();
        word_in = 32'hFFFF_FFFF;
        e = expect_word(32'h0, 8, 1'b1);
        stream(e, e.size(), 1'b0, "t4a");
        step();
        in_valid = 1'b0;
        e2 = expect_word(32'hFFFF_FFFF, 8, 1'b1);
        stream(e2, e2.size(), 1'b0, "t4b");

        // 5: reset after 3 digits, then clean restart
        in_valid = 1'b1; word_in = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        e = expect_word(32'h1234_5678, 8, 1'b1);
        stream(e, 5, 1'b0, "t5a");
        out_ready = 1'b0; rst_n = 1'b0;
        step();
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_inrdy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        in_valid = 1'b1; word_in = 32'h0000_000F;
        step();
        in_valid = 1'b0;
        e = expect_word(32'h0000_000F, 8, 1'b1);
        stream(e, e.size(), 1'b0, "t5b");

        // 6: pulse while busy is ignored
        base = accepted;
        in_valid = 1'b1; word_in = 32'hCAFE_0001;
        step();
        out_ready = 1'b0; word_in = 32'h1111_1111;
        step();
        in_valid = 1'b0;
        e = expect_word(32'hCAFE_0001, 8, 1'b1);
        stream(e, e.size(), 1'b0, "t6");
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_second", {31'd0, out_valid}, 32'd0);
            step();
        end
        chk("t6_count", 32'(accepted - base), 32'(e.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
